decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
- Parametrised, registered binary-to-one-hot decoder with N select bits and 2^N outputs.
- Direct mode: decodes the input index.
- Scan mode: an internal counter walks the outputs, holding each one for a programmable number of cycles (dwell); used for display-digit and row multiplexing.
- Next-generation decoder for the lab datapath, feeding LED/7-seg drivers and chip-select fan-out.

Parameters:
- N, 3, select width; output width is 2^N.
- DWELL, 4, cycles each output stays active in scan mode; legal range 1 to 65535.
- ACTIVE_LOW, 0, when 1 all y bits are inverted (the selected line is 0, idle lines are 1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; 0 blanks the outputs.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- load  in  1  scan mode only: load the scan index from a.
- a  in  N  select index in direct mode; start index on load.
- y  out  2^N  registered one-hot output, polarity per ACTIVE_LOW.
- idx  out  N  index currently driven on y.
- valid  out  1  1 when y carries a decoded line (not blanked).
- wrap  out  1  one-cycle pulse when the scan index wraps from 2^N-1 to 0.

Behaviour:
- Reset (asserted asynchronously, released synchronously):
  - idx=0, dwell counter=0, valid=0, wrap=0, state=IDLE.
  - y = all 0s, or all 1s when ACTIVE_LOW=1.
- States and transitions (evaluated at each clock edge):
  - IDLE when en=0, DIRECT when en=1 and mode=0, SCAN when en=1 and mode=1.
- IDLE:
  - y blanked (all inactive), valid=0, wrap=0.
  - idx and the dwell counter hold their values.
- DIRECT:
  - Latency 1 cycle: at the edge where a is sampled, idx<=a, y<=onehot(a) and valid<=1.
  - The dwell counter is cleared; load is ignored; wrap=0.
- SCAN:
  - Each cycle the dwell counter increments.
  - When the counter equals DWELL-1: counter<=0 and idx<=idx+1 modulo 2^N; y follows idx on the same edge.
  - wrap=1 for exactly the cycle after the step from 2^N-1 to 0.
  - DWELL=1 steps every cycle.
  - valid=1.
- load in SCAN:
  - idx<=a, dwell counter<=0, wrap=0.
  - Takes priority over a step that falls due in the same cycle.
  - The loaded line is then held for a full DWELL cycles.
- Mode and enable changes:
  - DIRECT to SCAN: scanning starts from the current idx with the dwell counter at 0.
  - SCAN to DIRECT: the next edge decodes a.
  - SCAN to IDLE to SCAN: resumes from the held idx and dwell count, with no extra step.
- Invariant: y is always either all inactive or has exactly one active bit, and that bit corresponds to idx.
- Width rules:
  - Dwell counter width is clog2(DWELL), minimum 1 bit.
  - The idx increment wraps naturally in N bits.
- Reset mid-scan: outputs return to reset values immediately; after release the block restarts from idx=0.

Decomposition:
- Shared package decoder_pkg: state encoding constants (IDLE, DIRECT, SCAN), a onehot function sized by N, and a clog2 helper.
- One sub-module, onehot_dec: the purely combinational N-to-2^N decode with polarity option, instantiated once and registered in decoder_scan.
- The FSM and the dwell/index counters stay in the top block.

Test Plan:
- Direct sweep: N=3, en=1, mode=0, a stepped 0 to 7 every 10 cycles.
  - One cycle after each change, y is 00000001, 00000010, and so on up to 10000000; idx=a; valid=1.
- Scan with DWELL=4: en=1, mode=1 from reset.
  - idx advances every 4 cycles: 0,1,...,7,0.
  - wrap is high for exactly 1 cycle at the 7-to-0 step, i.e. 32 cycles after scan start.
- Load priority: in scan, assert load with a=5 on the cycle a step is due.
  - idx=5 next cycle, held 4 cycles, then becomes 6; no wrap.
- Enable gating: deassert en for 3 cycles mid-dwell at idx=2, count=1.
  - y=0 and valid=0 while en=0.
  - On re-enable idx=2 and the step to 3 occurs after 2 more cycles.
- ACTIVE_LOW=1, N=2: direct decode of a=2.
  - y=1011; in IDLE y=1111.
- Async reset mid-scan at idx=6: drop rst_n between clock edges.
  - y, valid, wrap and idx clear immediately, without waiting for a clock edge.
  - After release the scan restarts at idx 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scan block.
//   state_t    : FSM state encoding (IDLE, DIRECT, SCAN), exposed for debug
//   MAX_N      : widest select supported by the onehot() helper
//   onehot()   : one-hot decode of a select value, MAX_W bits wide
//   clog2()    : ceiling log2 for sizing counters from parameters
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam int MAX_N = 8;
  localparam int MAX_W = 2 ** MAX_N;

  // Callers slice the low 2^N bits for their own select width.
  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] sel);
    logic [MAX_W-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

  // Smallest r with 2^r >= v (0 for v <= 1).
  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Bus bundle between the decoder_scan block and its controller.
//   en, mode, load, a : control and select inputs to the decoder
//   y, idx            : registered one-hot output and the index it shows
//   valid, wrap       : y carries a line / scan wrapped past the top index
//   state             : current FSM state, for debug and checkers
// There is no backpressure on this bus: valid simply qualifies y in the
// same cycle and the controller may change any input on any cycle.
interface decoder_scan_if
  import decoder_pkg::*;
#(
  parameter int N = 3
) ();

  logic            en;
  logic            mode;
  logic            load;
  logic [N-1:0]    a;
  logic [2**N-1:0] y;
  logic [N-1:0]    idx;
  logic            valid;
  logic            wrap;
  state_t          state;

  modport master (
    output en, mode, load, a,
    input  y, idx, valid, wrap, state
  );

  modport slave (
    input  en, mode, load, a,
    output y, idx, valid, wrap, state
  );

endinterface

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational N-to-2^N one-hot decoder with polarity option.
//   en  : 0 forces every line inactive
//   sel : index of the line to activate
//   y   : decoded lines; inverted when ACTIVE_LOW=1
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            en,
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] y
);

  localparam int W = 2 ** N;

  logic [W-1:0] raw;

  always_comb begin
    raw = '0;
    for (int i = 0; i < W; i++) begin
      raw[i] = en && (sel == N'(i));
    end
    y = ACTIVE_LOW ? ~raw : raw;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with direct and auto-scan modes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decoder_scan_if slave (en/mode/load/a in; y/idx/valid/
//                wrap/state out)
// Direct mode decodes a with one cycle of latency. Scan mode walks idx
// upward, holding each line for DWELL cycles; load restarts the walk at a.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);

  localparam int W      = 2 ** N;
  localparam int CW_RAW = clog2(DWELL);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [W-1:0]  Y_IDLE     = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};

  state_t        state_q, state_d;
  logic [N-1:0]  idx_q,   idx_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          valid_q, valid_d;
  logic          wrap_q,  wrap_d;
  logic [W-1:0]  y_q,     y_d;
  logic          dec_en;

  // The state follows the inputs sampled at this edge, and the actions of
  // that state are what get registered on the same edge.
  always_comb begin
    state_d = ST_IDLE;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;

    if (bus.en) begin
      state_d = bus.mode ? ST_SCAN : ST_DIRECT;
    end

    case (state_d)
      ST_DIRECT: begin
        idx_d   = bus.a;
        cnt_d   = '0;
        valid_d = 1'b1;
      end
      ST_SCAN: begin
        valid_d = 1'b1;
        if (bus.load) begin
          // Load beats a step falling due in the same cycle.
          idx_d = bus.a;
          cnt_d = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d  = '0;
          idx_d  = idx_q + 1'b1;
          wrap_d = (idx_q == {N{1'b1}});
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE: outputs blanked, index and dwell count hold.
      end
    endcase
  end

  // y follows the next index so the line and idx change on the same edge.
  assign dec_en = (state_d != ST_IDLE);

  onehot_dec #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .en  (dec_en),
    .sel (idx_d),
    .y   (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      y_q     <= Y_IDLE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan.
//   dut_m : N=3, DWELL=4, active-high  (main scoreboard-checked instance)
//   dut_l : N=2, DWELL=1, active-low   (polarity and every-cycle stepping)
module tb_decoder_scan;
  import decoder_pkg::*;

  localparam int DW = 4;

  logic clk;
  logic rst_n;

  decoder_scan_if #(.N(3)) m_if ();
  decoder_scan_if #(.N(2)) l_if ();

  decoder_scan #(.N(3), .DWELL(DW), .ACTIVE_LOW(1'b0)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  decoder_scan #(.N(2), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (l_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Packed as {y[7:0], idx[2:0], valid, wrap}.
  logic [12:0] exp_q[$];
  int          n_cmp;
  int          n_fail;
  logic [2:0]  m_idx;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of main-instance stimulus, predict its effect, then
  // compare the registered outputs just after the edge.
  task automatic main_cycle(input logic e, input logic md, input logic ld,
                            input logic [2:0] av, input string tag);
    logic [7:0]  ey;
    logic        ev;
    logic        ew;
    logic [12:0] got;
    logic [12:0] exp;
    m_if.en   = e;
    m_if.mode = md;
    m_if.load = ld;
    m_if.a    = av;
    ey = 8'h00;
    ev = 1'b0;
    ew = 1'b0;
    if (e) begin
      ev = 1'b1;
      if (!md || ld) begin
        m_idx = av;
        m_cnt = 0;
      end else if (m_cnt == DW - 1) begin
        m_cnt = 0;
        ew    = (m_idx == 3'd7);
        m_idx = m_idx + 3'd1;
      end else begin
        m_cnt++;
      end
      ey = 8'd1 << m_idx;
    end
    exp_q.push_back({ey, m_idx, ev, ew});
    @(posedge clk);
    #1;
    got = {m_if.y, m_if.idx, m_if.valid, m_if.wrap};
    exp = exp_q.pop_front();
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic low_edge(input logic e, input logic md, input logic [1:0] av);
    l_if.en   = e;
    l_if.mode = md;
    l_if.load = 1'b0;
    l_if.a    = av;
    @(posedge clk);
    #1;
  endtask

  // Hard bound in case a wait ever stalls.
  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int wrap_at;
    int wrap_cnt;
    n_cmp  = 0;
    n_fail = 0;
    m_idx  = 3'd0;
    m_cnt  = 0;
    rst_n  = 1'b0;
    m_if.en = 1'b0; m_if.mode = 1'b0; m_if.load = 1'b0; m_if.a = 3'd0;
    l_if.en = 1'b0; l_if.mode = 1'b0; l_if.load = 1'b0; l_if.a = 2'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y",     32'(m_if.y),     32'h00);
    chk("rst_idx",   32'(m_if.idx),   32'd0);
    chk("rst_valid", 32'(m_if.valid), 32'd0);
    chk("rst_wrap",  32'(m_if.wrap),  32'd0);
    chk("rst_state", 32'(m_if.state), 32'(ST_IDLE));
    chk("rst_y_low", 32'(l_if.y),     32'hf);
    @(negedge clk);
    rst_n = 1'b1;

    // Active-low, N=2: direct, idle, then DWELL=1 scanning.
    low_edge(1'b1, 1'b0, 2'd2);
    chk("low_direct_y",   32'(l_if.y),     32'b1011);
    chk("low_direct_idx", 32'(l_if.idx),   32'd2);
    chk("low_direct_v",   32'(l_if.valid), 32'd1);
    chk("low_state_dir",  32'(l_if.state), 32'(ST_DIRECT));
    low_edge(1'b0, 1'b0, 2'd0);
    chk("low_idle_y",     32'(l_if.y),     32'b1111);
    chk("low_idle_v",     32'(l_if.valid), 32'd0);
    low_edge(1'b1, 1'b1, 2'd0);
    chk("low_scan1_y",    32'(l_if.y),     32'b0111);
    chk("low_scan1_w",    32'(l_if.wrap),  32'd0);
    low_edge(1'b1, 1'b1, 2'd0);
    chk("low_scan2_y",    32'(l_if.y),     32'b1110);
    chk("low_scan2_w",    32'(l_if.wrap),  32'd1);
    low_edge(1'b1, 1'b1, 2'd0);
    chk("low_scan3_y",    32'(l_if.y),     32'b1101);
    chk("low_scan3_w",    32'(l_if.wrap),  32'd0);
    low_edge(1'b0, 1'b0, 2'd0);

    // Direct sweep, a held for 10 cycles each.
    for (int av = 0; av < 8; av++) begin
      for (int c = 0; c < 10; c++) begin
        main_cycle(1'b1, 1'b0, 1'b0, 3'(av), "direct");
        if (c == 0) chk("direct_onehot", 32'(m_if.y), 32'd1 << av);
      end
    end
    chk("direct_last_y", 32'(m_if.y), 32'h80);

    // Scan from reset: wrap exactly 32 cycles after scan start.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_idx = 3'd0;
    m_cnt = 0;
    wrap_at  = 0;
    wrap_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "scan");
      if (i == 1) chk("scan_state", 32'(m_if.state), 32'(ST_SCAN));
      if (i == 4) chk("scan_idx1",  32'(m_if.idx),   32'd1);
      if (m_if.wrap === 1'b1) begin
        wrap_cnt++;
        if (wrap_at == 0) wrap_at = i;
      end
    end
    chk("wrap_cycle", 32'(wrap_at),  32'd32);
    chk("wrap_count", 32'(wrap_cnt), 32'd1);

    // Load with a=5 on the cycle a step is due.
    for (int k = 0; k < 8 && m_cnt != DW - 1; k++)
      main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "scan_pre_load");
    chk("load_setup", 32'(m_cnt), 32'(DW - 1));
    main_cycle(1'b1, 1'b1, 1'b1, 3'd5, "load");
    chk("load_idx", 32'(m_if.idx), 32'd5);
    for (int j = 0; j < 3; j++)
      main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "load_hold");
    chk("load_hold_idx", 32'(m_if.idx), 32'd5);
    main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "load_step");
    chk("load_step_idx",  32'(m_if.idx),  32'd6);
    chk("load_step_wrap", 32'(m_if.wrap), 32'd0);

    // Enable gating mid-dwell at idx=2, count=1.
    for (int k = 0; k < 64 && !(m_idx == 3'd2 && m_cnt == 1); k++)
      main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "scan_pre_gate");
    chk("gate_setup", 32'({m_idx, 8'(m_cnt)}), 32'({3'd2, 8'd1}));
    for (int j = 0; j < 3; j++) begin
      main_cycle(1'b0, 1'b1, 1'b0, 3'd0, "gate_off");
      chk("gate_off_y", 32'(m_if.y),     32'h00);
      chk("gate_off_v", 32'(m_if.valid), 32'd0);
    end
    main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "gate_on");
    main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "gate_on");
    chk("gate_hold_idx", 32'(m_if.idx), 32'd2);
    main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "gate_step");
    chk("gate_step_idx", 32'(m_if.idx), 32'd3);

    // Asynchronous reset mid-scan at idx=6.
    for (int k = 0; k < 64 && m_idx != 3'd6; k++)
      main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "scan_pre_rst");
    chk("arst_setup", 32'(m_if.idx), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y",     32'(m_if.y),     32'h00);
    chk("arst_valid", 32'(m_if.valid), 32'd0);
    chk("arst_wrap",  32'(m_if.wrap),  32'd0);
    chk("arst_idx",   32'(m_if.idx),   32'd0);
    m_idx = 3'd0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++)
      main_cycle(1'b1, 1'b1, 1'b0, 3'd0, "post_rst_scan");
    chk("post_rst_idx", 32'(m_if.idx), 32'd1);
    chk("exp_q_empty",  32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
